// File: rtl/dbus_pkg.sv
// Shared types and default widths for the data-side bus bridge.
package dbus_pkg;

  localparam int DBUS_AW = 32;
  localparam int DBUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } dbus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; the bridge uses it to post stores.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             pushEn;
  logic             popEn;

  // A push while full is refused even if a pop frees a slot in the same cycle.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushEn  = push_i && !full_o;
  assign popEn   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + PW'(1);
      if (popEn)  rdPtr_q <= rdPtr_q + PW'(1);
      if (pushEn && !popEn)      count_q <= count_q + CW'(1);
      else if (popEn && !pushEn) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/dbus_bridge.sv
// Turns the core's combinational load/store port into a valid/ready memory bus,
// posting stores through a write buffer and stalling the core on loads.
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int AW = DBUS_AW,
  parameter int DW = DBUS_DW,
  parameter int WB_DEPTH = 4,
  localparam int CW = $clog2(WB_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_rdata,
  output logic [CW-1:0] wb_count
);

  dbus_state_e      state_q;
  logic [DW-1:0]    rdata_q;
  logic [AW+DW-1:0] fifoIn;
  logic [AW+DW-1:0] fifoHead;
  logic [AW-1:0]    headAddr;
  logic [DW-1:0]    headData;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             fifoPush;
  logic             fifoPop;
  logic [CW-1:0]    fifoCount;
  logic             storeReq;
  logic             drainValid;

  // A simultaneous load and store is illegal; the load wins.
  assign storeReq   = cpu_memwrite && !cpu_memread;
  assign fifoIn     = {cpu_addr, cpu_wdata};
  assign headAddr   = fifoHead[AW+DW-1:DW];
  assign headData   = fifoHead[DW-1:0];
  assign drainValid = (state_q == IDLE) && !fifoEmpty;

  always_comb begin
    cpu_stall = 1'b0;
    case (state_q)
      IDLE:            cpu_stall = cpu_memread || (storeReq && fifoFull);
      RD_REQ, RD_WAIT: cpu_stall = 1'b1;
      RD_DONE:         cpu_stall = storeReq && fifoFull;
      default:         cpu_stall = 1'b0;
    endcase
  end

  // A store is enqueued exactly in the cycle its stall drops.
  assign fifoPush = storeReq && !cpu_stall;
  assign fifoPop  = drainValid && mem_req_ready;

  // The drained head is stable until accepted, and the read address comes
  // from the core, which is held by the stall while RD_REQ waits.
  assign mem_req_valid = drainValid || (state_q == RD_REQ);
  assign mem_req_we    = drainValid;
  assign mem_req_addr  = drainValid ? headAddr : cpu_addr;
  assign mem_req_wdata = headData;

  assign cpu_rdata = rdata_q;
  assign wb_count  = fifoCount;

  sync_fifo #(
    .WIDTH(AW + DW),
    .DEPTH(WB_DEPTH)
  ) u_wbuf (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (fifoPush),
    .pop_i  (fifoPop),
    .data_i (fifoIn),
    .data_o (fifoHead),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .count_o(fifoCount)
  );

  // Reads only issue once the buffer is empty, so loads never bypass stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_memread && (fifoEmpty || (fifoCount == CW'(1) && fifoPop)))
            state_q <= RD_REQ;
        end
        RD_REQ: begin
          if (mem_req_ready) state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_rdata;
            state_q <= RD_DONE;
          end
        end
        RD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed and randomized-delay bench for dbus_bridge with a small memory model.
module tb_dbus_bridge;

  localparam int CW    = 3;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [CW-1:0] wb_count;

  int total = 0;
  int bad   = 0;

  dbus_bridge #(.AW(32), .DW(32), .WB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Memory model: ready after readyDelay waiting cycles, read data rspDelay
  // extra cycles after the accepting edge.
  bit          forceReadyLow = 1'b0;
  int          readyDelay = 0;
  int          rspDelay = 0;
  int          waitCnt = 0;
  logic        rspValidQ;
  logic [31:0] rspDataQ;
  bit          rspPending;
  int          rspTimer;
  logic [31:0] rspPendData;
  bit          injectRsp = 1'b0;
  logic [31:0] injectData = 32'h0;
  logic [31:0] memModel [256];
  logic [64:0] txnLog [$];

  function automatic logic [31:0] defaultWord(input int idx);
    logic [7:0] b;
    b = idx[7:0];
    return {8'h00, b, 16'hC0DE};
  endfunction

  assign mem_req_ready = !forceReadyLow && (waitCnt >= readyDelay);
  assign mem_rsp_valid = rspValidQ | injectRsp;
  assign mem_rsp_rdata = injectRsp ? injectData : rspDataQ;

  always @(posedge clk) begin
    if (reset) begin
      waitCnt    <= 0;
      rspValidQ  <= 1'b0;
      rspDataQ   <= '0;
      rspPending <= 1'b0;
      rspTimer   <= 0;
      for (int i = 0; i < 256; i++) memModel[i] <= defaultWord(i);
    end else begin
      rspValidQ <= 1'b0;
      if (rspPending) begin
        if (rspTimer == 0) begin
          rspValidQ  <= 1'b1;
          rspDataQ   <= rspPendData;
          rspPending <= 1'b0;
        end else begin
          rspTimer <= rspTimer - 1;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        waitCnt <= 0;
        txnLog.push_back({mem_req_we, mem_req_addr, mem_req_wdata});
        if (mem_req_we) begin
          memModel[mem_req_addr[9:2]] <= mem_req_wdata;
        end else if (rspDelay == 0) begin
          rspValidQ <= 1'b1;
          rspDataQ  <= memModel[mem_req_addr[9:2]];
        end else begin
          rspPending  <= 1'b1;
          rspTimer    <= rspDelay - 1;
          rspPendData <= memModel[mem_req_addr[9:2]];
        end
      end else if (mem_req_valid) begin
        waitCnt <= waitCnt + 1;
      end
    end
  end

  // Request must hold valid/we/addr/wdata while it waits for ready.
  logic        heldV = 1'b0;
  logic [64:0] heldSnap;
  always @(negedge clk) begin
    assert (!(cpu_memread && cpu_memwrite)) else $error("[TB] illegal load+store driven");
    if (reset) begin
      heldV = 1'b0;
    end else begin
      if (heldV) begin
        total++;
        if (!mem_req_valid || {mem_req_we, mem_req_addr, mem_req_wdata} !== heldSnap) begin
          bad++;
          $display("[TB] FAIL reqStable got=%b/%h want=1/%h", mem_req_valid,
                   {mem_req_we, mem_req_addr, mem_req_wdata}, heldSnap);
        end
      end
      heldV    = mem_req_valid && !mem_req_ready;
      heldSnap = {mem_req_we, mem_req_addr, mem_req_wdata};
    end
  end

  task automatic waitRelease(output int stalls, output logic [31:0] rd);
    stalls = 0;
    rd = 'x;
    forever begin
      @(negedge clk);
      if (!cpu_stall) begin
        rd = cpu_rdata;
        break;
      end
      stalls++;
      if (stalls >= LIMIT) begin
        total++; bad++;
        $display("[TB] FAIL opTimeout got=%0d stall cycles want<%0d", stalls, LIMIT);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d, output int stalls);
    logic [31:0] unusedRd;
    cpu_memwrite = 1'b1; cpu_addr = a; cpu_wdata = d;
    waitRelease(stalls, unusedRd);
    cpu_memwrite = 1'b0;
  endtask

  task automatic doLoad(input logic [31:0] a, output logic [31:0] rd, output int stalls);
    cpu_memread = 1'b1; cpu_addr = a;
    waitRelease(stalls, rd);
    cpu_memread = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (wb_count == 0) break;
      n++;
      if (n >= LIMIT) begin
        total++; bad++;
        $display("[TB] FAIL drainTimeout got=%0d want=0", wb_count);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (wb_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_wbCount got=%0d want=0", wb_count); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", mem_req_valid); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", cpu_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", cpu_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_store();
    readyDelay = 0;
    cpu_memwrite = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL store_stall got=%b want=0", cpu_stall); end
    @(posedge clk); #1;
    cpu_memwrite = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== {2'b11, 32'h40, 32'hDEAD_BEEF}) begin
      bad++;
      $display("[TB] FAIL store_req got=%b%b/%h/%h want=11/00000040/deadbeef",
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
    end
    total++; if (wb_count !== 3'd1) begin bad++; $display("[TB] FAIL store_count1 got=%0d want=1", wb_count); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL store_drainStall got=%b want=0", cpu_stall); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (wb_count !== 3'd0) begin bad++; $display("[TB] FAIL store_count0 got=%0d want=0", wb_count); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL store_idleValid got=%b want=0", mem_req_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int stalls;
    int base;
    logic [64:0] got;
    logic [64:0] want;
    forceReadyLow = 1'b1;
    base = txnLog.size();
    for (int i = 0; i < 4; i++) begin
      doStore(32'h100 + (32'(i) << 2), 32'h1000_0000 + 32'(i), stalls);
      total++; if (stalls != 0) begin bad++; $display("[TB] FAIL b2b_zeroStall%0d got=%0d want=0", i, stalls); end
    end
    cpu_memwrite = 1'b1; cpu_addr = 32'h110; cpu_wdata = 32'h1000_0004;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (cpu_stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b_fullStall got=%b want=1", cpu_stall); end
      total++; if (wb_count !== 3'd4) begin bad++; $display("[TB] FAIL b2b_fullCount got=%0d want=4", wb_count); end
      @(posedge clk); #1;
    end
    forceReadyLow = 1'b0;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b_noBypass got=%b want=1", cpu_stall); end
    total++;
    if ({mem_req_valid, mem_req_we, mem_req_addr} !== {2'b11, 32'h100}) begin
      bad++; $display("[TB] FAIL b2b_head got=%b%b/%h want=11/00000100", mem_req_valid, mem_req_we, mem_req_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_release got=%b want=0", cpu_stall); end
    total++; if (wb_count !== 3'd3) begin bad++; $display("[TB] FAIL b2b_count3 got=%0d want=3", wb_count); end
    @(posedge clk); #1;
    cpu_memwrite = 1'b0;
    waitDrain();
    total++; if (txnLog.size() != base + 5) begin bad++; $display("[TB] FAIL b2b_writeCount got=%0d want=5", txnLog.size() - base); end
    for (int i = 0; i < 5; i++) begin
      got  = (base + i < txnLog.size()) ? txnLog[base + i] : 'x;
      want = {1'b1, 32'h100 + (32'(i) << 2), 32'h1000_0000 + 32'(i)};
      total++; if (got !== want) begin bad++; $display("[TB] FAIL b2b_order%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_load();
    int stalls;
    logic [31:0] rd;
    logic [64:0] got;
    readyDelay = 0; rspDelay = 0;
    doStore(32'h80, 32'h1234_5678, stalls);
    waitDrain();
    doLoad(32'h80, rd, stalls);
    total++; if (stalls != 3) begin bad++; $display("[TB] FAIL load_stallCycles got=%0d want=3", stalls); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("[TB] FAIL load_data got=%h want=12345678", rd); end
    got = (txnLog.size() > 0) ? txnLog[txnLog.size() - 1] : 'x;
    total++; if (got[64:32] !== {1'b0, 32'h80}) begin bad++; $display("[TB] FAIL load_req got=%h want=0_00000080", got[64:32]); end
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL load_hold got=%h want=12345678", cpu_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL load_idleStall got=%b want=0", cpu_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int stalls;
    int base;
    logic [31:0] rd;
    logic [64:0] got;
    base = txnLog.size();
    doStore(32'h10, 32'h0000_A5A5, stalls);
    total++; if (stalls != 0) begin bad++; $display("[TB] FAIL raw_storeStall got=%0d want=0", stalls); end
    doLoad(32'h10, rd, stalls);
    total++; if (rd !== 32'h0000_A5A5) begin bad++; $display("[TB] FAIL raw_data got=%h want=0000a5a5", rd); end
    got = (base < txnLog.size()) ? txnLog[base] : 'x;
    total++; if (got !== {1'b1, 32'h10, 32'h0000_A5A5}) begin bad++; $display("[TB] FAIL raw_first got=%h want=write 10/a5a5", got); end
    got = (base + 1 < txnLog.size()) ? txnLog[base + 1] : 'x;
    total++; if (got[64:32] !== {1'b0, 32'h10}) begin bad++; $display("[TB] FAIL raw_second got=%h want=read 10", got[64:32]); end
  endtask

  task automatic test_spurious_reset();
    int stalls;
    int base;
    logic [31:0] rd;
    injectData = 32'hBAD0_BAD0; injectRsp = 1'b1;
    @(posedge clk); #1;
    injectRsp = 1'b0;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h0000_A5A5) begin bad++; $display("[TB] FAIL spurious_rdata got=%h want=0000a5a5", cpu_rdata); end
    @(posedge clk); #1;
    readyDelay = 0; rspDelay = 7;
    cpu_memread = 1'b1; cpu_addr = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({cpu_stall, mem_req_valid} !== 2'b10) begin bad++; $display("[TB] FAIL rdwait_state got=%b want=10", {cpu_stall, mem_req_valid}); end
    reset = 1'b1; cpu_memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (wb_count !== 3'd0) begin bad++; $display("[TB] FAIL midReset_count got=%0d want=0", wb_count); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL midReset_valid got=%b want=0", mem_req_valid); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL midReset_rdata got=%h want=0", cpu_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL midReset_stall got=%b want=0", cpu_stall); end
    @(posedge clk); #1;
    rspDelay = 0;
    doLoad(32'h20, rd, stalls);
    total++; if (stalls != 3) begin bad++; $display("[TB] FAIL postReset_stalls got=%0d want=3", stalls); end
    total++; if (rd !== 32'h0008_C0DE) begin bad++; $display("[TB] FAIL postReset_data got=%h want=0008c0de", rd); end
    forceReadyLow = 1'b1;
    doStore(32'h30, 32'h1, stalls);
    doStore(32'h34, 32'h2, stalls);
    @(negedge clk);
    total++; if (wb_count !== 3'd2) begin bad++; $display("[TB] FAIL bufPre_count got=%0d want=2", wb_count); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; forceReadyLow = 1'b0;
    base = txnLog.size();
    @(negedge clk);
    total++; if (wb_count !== 3'd0) begin bad++; $display("[TB] FAIL bufDrop_count got=%0d want=0", wb_count); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL bufDrop_valid got=%b want=0", mem_req_valid); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (txnLog.size() != base) begin bad++; $display("[TB] FAIL bufDrop_writes got=%0d want=0", txnLog.size() - base); end
  endtask

  task automatic test_random();
    logic [31:0] refMem [256];
    logic [31:0] rd;
    logic [31:0] d;
    logic [31:0] a;
    int stalls;
    int kind;
    int idx;
    for (int i = 0; i < 256; i++) refMem[i] = defaultWord(i);
    for (int n = 0; n < 1000; n++) begin
      kind = $urandom_range(2, 0);
      idx  = $urandom_range(15, 0);
      a    = 32'(idx) << 2;
      readyDelay = $urandom_range(7, 0);
      rspDelay   = $urandom_range(7, 0);
      case (kind)
        0: begin
          d = $urandom;
          doStore(a, d, stalls);
          refMem[idx] = d;
        end
        1: begin
          doLoad(a, rd, stalls);
          total++;
          if (rd !== refMem[idx]) begin
            bad++; $display("[TB] FAIL rand_load%0d addr=%h got=%h want=%h", n, a, rd, refMem[idx]);
          end
        end
        default: begin
          @(negedge clk);
          total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL rand_idleStall%0d got=%b want=0", n, cpu_stall); end
          @(posedge clk); #1;
        end
      endcase
    end
    waitDrain();
  endtask

  initial begin
    reset = 1'b1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_single_store();
    test_back_to_back();
    test_load();
    test_store_load();
    test_spurious_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
